id_stage_pipe: RTL
==================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode-stage datapath and ID/EX pipeline register for the RV32I core.
//  - Holds the register file (2R/1W); x0 reads zero.
//  - Detects load-use hazards over a configurable load latency and inserts bubbles.
//  - Drives pc_en/stall upstream and a valid-qualified ID/EX register downstream.
//  - Sits between the decoder (control bundle input) and the EX stage.
// PARAMETERS
//  DATA_WIDTH     32  register/data width
//  REGADDR_WIDTH  5   register address width; NUM_REGS = 2**REGADDR_WIDTH
//  CTRL_WIDTH     16  opaque decoded-control bundle carried to EX (alu_op, op_b_sel, ...)
//  LOAD_LAT       1   cycles after EX entry before a load result is forwardable (1..4)
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous active-high reset
//  id_valid       in   1              instruction present in ID
//  rs1_addr_id    in   REGADDR_WIDTH  source 1 address
//  rs2_addr_id    in   REGADDR_WIDTH  source 2 address
//  rd_addr_id     in   REGADDR_WIDTH  destination address
//  uses_rs1_id    in   1              instruction reads rs1
//  uses_rs2_id    in   1              instruction reads rs2
//  ram_read_id    in   1              instruction is a load
//  ctrl_id        in   CTRL_WIDTH     decoded control bundle
//  ex_ready       in   1              EX can accept (0 = downstream stall)
//  flush          in   1              kill instruction entering EX (taken branch/jump)
//  regs_write_wb  in   1              WB write enable
//  rd_addr_wb     in   REGADDR_WIDTH  WB write address
//  regs_write_data in  DATA_WIDTH     WB write data
//  pc_en          out  1              IF/PC may advance
//  stall          out  1              ID holds current instruction
//  ex_valid       out  1              ID/EX register holds a real instruction
//  rs1_data_ex    out  DATA_WIDTH     registered rs1 value
//  rs2_data_ex    out  DATA_WIDTH     registered rs2 value
//  rd_addr_ex     out  REGADDR_WIDTH  registered rd
//  ram_read_ex    out  1              registered load flag (0 when !ex_valid)
//  ctrl_ex        out  CTRL_WIDTH     registered control bundle (0 when !ex_valid)
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge): all regfile entries, ID/EX fields, ex_valid and pending[] go to 0.
//  - Reset mid-operation discards everything in flight.
//  - Regfile: writes with rd_addr_wb==0 are ignored; reading x0 always returns 0.
//  - pending[0..LOAD_LAT-1] are rd tags of in-flight loads; 0 means empty.
//    - pending[0] = (ex_valid && ram_read_ex) ? rd_addr_ex : 0.
//    - When ex_ready=1, pending[k] <= pending[k-1] for k>=1; otherwise hold.
//  - load_hazard = id_valid && any k: pending[k]!=0 &&
//    ((uses_rs1_id && rs1==pending[k]) || (uses_rs2_id && rs2==pending[k])).
//  - stall = load_hazard || !ex_ready; pc_en = !stall. Both are combinational.
//  - ID/EX update, in priority order:
//    - flush:                        ex_valid<=0, ram_read_ex<=0, ctrl_ex<=0 (flush beats hold)
//    - !ex_ready:                    hold all fields
//    - load_hazard:                  bubble (ex_valid<=0, ram_read_ex<=0, ctrl_ex<=0)
//    - else:                         capture: ex_valid<=id_valid; data, rd, load, ctrl from ID
//  - A flushed slot never creates a pending tag.
//  - Latency: 1 cycle from ID to EX. Bubbles inserted = LOAD_LAT - (distance to the load) + 1.
//  - Simultaneous WB write and ID read of the same nonzero register: see CONFIGURATION.
// CONFIGURATION
//  ID_BYPASS_EN defined:
//    - Same-cycle WB write to rs1/rs2 (nonzero) is bypassed to the ID read value (write-through).
//  ID_BYPASS_EN undefined:
//    - Read returns the pre-write value.
//    - The core must then treat WB as one extra pending stage; hazard logic here is unchanged.
// TESTING
//  - rst=1 one cycle -> ex_valid=0, ctrl_ex=0, every register reads 0; write x0=5 -> x0 still reads 0.
//  - LOAD_LAT=1: lw x5, then add x6,x5,x1 -> exactly 1 bubble (ex_valid=0 one cycle); stall=1 and pc_en=0 that cycle.
//  - LOAD_LAT=3: lw x5, nop, use x5 -> 2 bubbles; use of x7 (not pending) -> 0 bubbles.
//  - ex_ready=0 for 3 cycles with valid ID -> ID/EX fields and pending[] hold; stall=1 throughout.
//  - flush=1 together with ex_ready=0 and a load in ID -> ex_valid=0 next cycle, no pending tag for it.
//  - WB writes x3=0xDEADBEEF while ID reads x3 -> rs1_data_ex=0xDEADBEEF with ID_BYPASS_EN; old value without it.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// Bus bundle between the decoder/WB side and the ID stage of the RV32I core.
// Carries the decoded instruction in ID, the EX handshake (ex_ready, flush), the WB
// register-file write port, and the ID/EX register outputs plus pc_en/stall.
// Modports:
//   master - decoder/WB/EX side: drives the ID-stage inputs, observes the ID/EX outputs
//   slave  - the ID stage itself (id_stage_pipe)
interface id_stage_pipe_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned REGADDR_WIDTH = 5,
   parameter int unsigned CTRL_WIDTH    = 16
);
   logic                     id_valid;
   logic [REGADDR_WIDTH-1:0] rs1_addr_id;
   logic [REGADDR_WIDTH-1:0] rs2_addr_id;
   logic [REGADDR_WIDTH-1:0] rd_addr_id;
   logic                     uses_rs1_id;
   logic                     uses_rs2_id;
   logic                     ram_read_id;
   logic [CTRL_WIDTH-1:0]    ctrl_id;
   logic                     ex_ready;
   logic                     flush;
   logic                     regs_write_wb;
   logic [REGADDR_WIDTH-1:0] rd_addr_wb;
   logic [DATA_WIDTH-1:0]    regs_write_data;

   logic                     pc_en;
   logic                     stall;
   logic                     ex_valid;
   logic [DATA_WIDTH-1:0]    rs1_data_ex;
   logic [DATA_WIDTH-1:0]    rs2_data_ex;
   logic [REGADDR_WIDTH-1:0] rd_addr_ex;
   logic                     ram_read_ex;
   logic [CTRL_WIDTH-1:0]    ctrl_ex;

   modport master (
      output id_valid, rs1_addr_id, rs2_addr_id, rd_addr_id, uses_rs1_id, uses_rs2_id,
             ram_read_id, ctrl_id, ex_ready, flush, regs_write_wb, rd_addr_wb,
             regs_write_data,
      input  pc_en, stall, ex_valid, rs1_data_ex, rs2_data_ex, rd_addr_ex, ram_read_ex,
             ctrl_ex
   );

   modport slave (
      input  id_valid, rs1_addr_id, rs2_addr_id, rd_addr_id, uses_rs1_id, uses_rs2_id,
             ram_read_id, ctrl_id, ex_ready, flush, regs_write_wb, rd_addr_wb,
             regs_write_data,
      output pc_en, stall, ex_valid, rs1_data_ex, rs2_data_ex, rd_addr_ex, ram_read_ex,
             ctrl_ex
   );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode-stage datapath and ID/EX pipeline register for the RV32I core.
// Holds the 2R/1W register file (x0 reads zero), detects load-use hazards against loads
// still within LOAD_LAT cycles of EX entry, inserts bubbles, and drives pc_en/stall.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - id_stage_pipe_if.slave: ID inputs, EX handshake, WB write port, ID/EX outputs
// Build option:
//   ID_BYPASS_EN - when defined, a same-cycle WB write to a nonzero rs1/rs2 is forwarded
//                  into the ID read; otherwise the read returns the pre-write value.
module id_stage_pipe #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned REGADDR_WIDTH = 5,
   parameter int unsigned CTRL_WIDTH    = 16,
   parameter int unsigned LOAD_LAT      = 1
) (
   input  logic           clk,
   input  logic           rst,
   id_stage_pipe_if.slave bus
);
   localparam int unsigned NUM_REGS = 2 ** REGADDR_WIDTH;

   logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]    rs1_rdata;
   logic [DATA_WIDTH-1:0]    rs2_rdata;

   logic                     ex_valid_q;
   logic                     ram_read_ex_q;
   logic [REGADDR_WIDTH-1:0] rd_addr_ex_q;
   logic [CTRL_WIDTH-1:0]    ctrl_ex_q;
   logic [DATA_WIDTH-1:0]    rs1_data_ex_q;
   logic [DATA_WIDTH-1:0]    rs2_data_ex_q;

   logic [REGADDR_WIDTH-1:0] pend0;
   logic [LOAD_LAT-1:0][REGADDR_WIDTH-1:0] pending;
   logic                     load_hazard;
   logic                     stall_w;

   // Register file read, x0 hardwired to zero.
   always_comb begin
      rs1_rdata = (bus.rs1_addr_id == '0) ? '0 : regs_q[bus.rs1_addr_id];
      rs2_rdata = (bus.rs2_addr_id == '0) ? '0 : regs_q[bus.rs2_addr_id];
`ifdef ID_BYPASS_EN
      if (bus.regs_write_wb && (bus.rd_addr_wb != '0)) begin
         if (bus.rd_addr_wb == bus.rs1_addr_id) rs1_rdata = bus.regs_write_data;
         if (bus.rd_addr_wb == bus.rs2_addr_id) rs2_rdata = bus.regs_write_data;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (bus.regs_write_wb && (bus.rd_addr_wb != '0)) begin
         regs_q[bus.rd_addr_wb] <= bus.regs_write_data;
      end
   end

   // Tag 0 means "no load in this slot"; x0 can never be a hazard.
   assign pend0 = (ex_valid_q && ram_read_ex_q) ? rd_addr_ex_q : '0;

   // Older in-flight loads age one slot per cycle EX advances.
   if (LOAD_LAT > 1) begin : g_pend
      logic [LOAD_LAT-2:0][REGADDR_WIDTH-1:0] pend_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            pend_q <= '0;
         end else if (bus.ex_ready) begin
            pend_q[0] <= pend0;
            for (int unsigned k = 1; k < LOAD_LAT - 1; k++) pend_q[k] <= pend_q[k-1];
         end
      end

      assign pending = {pend_q, pend0};
   end else begin : g_nopend
      assign pending = pend0;
   end

   always_comb begin
      load_hazard = 1'b0;
      for (int unsigned k = 0; k < LOAD_LAT; k++) begin
         if ((pending[k] != '0) &&
             ((bus.uses_rs1_id && (bus.rs1_addr_id == pending[k])) ||
              (bus.uses_rs2_id && (bus.rs2_addr_id == pending[k])))) begin
            load_hazard = 1'b1;
         end
      end
      load_hazard = load_hazard && bus.id_valid;
   end

   assign stall_w   = load_hazard || !bus.ex_ready;
   assign bus.stall = stall_w;
   assign bus.pc_en = !stall_w;

   // ID/EX register: flush beats hold; hazard inserts a bubble; otherwise capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q    <= 1'b0;
         ram_read_ex_q <= 1'b0;
         ctrl_ex_q     <= '0;
         rd_addr_ex_q  <= '0;
         rs1_data_ex_q <= '0;
         rs2_data_ex_q <= '0;
      end else if (bus.flush) begin
         ex_valid_q    <= 1'b0;
         ram_read_ex_q <= 1'b0;
         ctrl_ex_q     <= '0;
      end else if (bus.ex_ready) begin
         if (load_hazard) begin
            ex_valid_q    <= 1'b0;
            ram_read_ex_q <= 1'b0;
            ctrl_ex_q     <= '0;
         end else begin
            ex_valid_q    <= bus.id_valid;
            ram_read_ex_q <= bus.id_valid && bus.ram_read_id;
            ctrl_ex_q     <= bus.id_valid ? bus.ctrl_id : '0;
            rd_addr_ex_q  <= bus.rd_addr_id;
            rs1_data_ex_q <= rs1_rdata;
            rs2_data_ex_q <= rs2_rdata;
         end
      end
   end

   assign bus.ex_valid    = ex_valid_q;
   assign bus.ram_read_ex = ram_read_ex_q;
   assign bus.ctrl_ex     = ctrl_ex_q;
   assign bus.rd_addr_ex  = rd_addr_ex_q;
   assign bus.rs1_data_ex = rs1_data_ex_q;
   assign bus.rs2_data_ex = rs2_data_ex_q;
endmodule
